// File: rtl/temp_monitor_pkg.sv
// Shared definitions for the temperature alarm monitor: alarm FSM state
// encodings, default threshold/persistence constants and a parameter
// legality check used at elaboration time.
package temp_monitor_pkg;

  // Alarm FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_NORMAL    = 3'd0,
    ST_PEND_LOW  = 3'd1,
    ST_PEND_HIGH = 3'd2,
    ST_LOW       = 3'd3,
    ST_HIGH      = 3'd4
  } alarm_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LOW_TH  = 35;
  localparam int DEF_HIGH_TH = 39;
  localparam int DEF_HYST    = 1;
  localparam int DEF_PERSIST = 3;
  localparam int DEF_CNT_W   = 8;

  // True when the clear points do not cross each other, the low clear point
  // cannot underflow, and at least one sample is needed to raise an alarm.
  function automatic bit thresholdsLegal(input int lowTh, input int highTh,
                                         input int hyst, input int persist);
    return (persist >= 1) && (hyst <= lowTh) && ((lowTh + hyst) <= (highTh - hyst));
  endfunction

endpackage

// File: rtl/temp_stats_tracker.sv
// Min/max/statsValid tracking for the status/display path. A clear pulse
// restores the empty-statistics values; a sample arriving in the same cycle
// as the clear becomes the first sample of the new window.
module temp_stats_tracker
  import temp_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             clearStats_i,
  output logic [WIDTH-1:0] minTemp_o,
  output logic [WIDTH-1:0] maxTemp_o,
  output logic             statsValid_o
);

  logic [WIDTH-1:0] minTemp_q, minTemp_d;
  logic [WIDTH-1:0] maxTemp_q, maxTemp_d;
  logic             statsValid_q, statsValid_d;

  // Next statistics: apply the clear first so a coincident sample reloads min and max.
  always_comb begin
    minTemp_d    = minTemp_q;
    maxTemp_d    = maxTemp_q;
    statsValid_d = statsValid_q;
    if (clearStats_i) begin
      minTemp_d    = '1;
      maxTemp_d    = '0;
      statsValid_d = 1'b0;
    end
    if (sampleValid_i) begin
      if (sample_i < minTemp_d) begin
        minTemp_d = sample_i;
      end
      if (sample_i > maxTemp_d) begin
        maxTemp_d = sample_i;
      end
      statsValid_d = 1'b1;
    end
  end

  // Statistics registers with asynchronous reset to the empty window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minTemp_q    <= '1;
      maxTemp_q    <= '0;
      statsValid_q <= 1'b0;
    end else begin
      minTemp_q    <= minTemp_d;
      maxTemp_q    <= maxTemp_d;
      statsValid_q <= statsValid_d;
    end
  end

  assign minTemp_o    = minTemp_q;
  assign maxTemp_o    = maxTemp_q;
  assign statsValid_o = statsValid_q;

endmodule

// File: rtl/temp_alarm_monitor.sv
// Temperature alarm monitor: classifies valid samples as low/normal/high,
// raises an alarm only after PERSIST consecutive abnormal valid samples,
// clears it with hysteresis, and counts alarm entries (saturating).
// Min/max statistics are delegated to temp_stats_tracker.
module temp_alarm_monitor
  import temp_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LOW_TH  = DEF_LOW_TH,
  parameter int HIGH_TH = DEF_HIGH_TH,
  parameter int HYST    = DEF_HYST,
  parameter int PERSIST = DEF_PERSIST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid_i,
  input  logic [WIDTH-1:0] temperature_i,
  input  logic             clearStats_i,
  output logic             lowTempAbnormality_o,
  output logic             highTempAbnormality_o,
  output logic [WIDTH-1:0] minTemp_o,
  output logic [WIDTH-1:0] maxTemp_o,
  output logic             statsValid_o,
  output logic [CNT_W-1:0] eventCount_o
);

  // Reject parameter sets whose clear points overlap or underflow.
  if (!thresholdsLegal(LOW_TH, HIGH_TH, HYST, PERSIST)) begin : gIllegalParams
    $error("temp_alarm_monitor: illegal LOW_TH/HIGH_TH/HYST/PERSIST combination");
  end

  // Thresholds and clear points are folded into WIDTH-bit constants.
  localparam logic [WIDTH-1:0] LOW_TH_C   = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] HIGH_TH_C  = WIDTH'(HIGH_TH);
  localparam logic [WIDTH-1:0] LOW_CLR_C  = WIDTH'(LOW_TH + HYST);
  localparam logic [WIDTH-1:0] HIGH_CLR_C = WIDTH'(HIGH_TH - HYST);

  // Persistence counter only ever needs to reach PERSIST.
  localparam int               PCNT_W    = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
  localparam logic [PCNT_W-1:0] PERSIST_C = PCNT_W'(PERSIST);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  alarm_state_e      state_q, state_d;
  logic [PCNT_W-1:0] persistCnt_q, persistCnt_d;
  logic [PCNT_W-1:0] persistInc;
  logic              lowAlarm_q, highAlarm_q;
  logic [CNT_W-1:0]  eventCount_q, eventCount_d;
  logic              rawLow, rawHigh;
  logic              alarmEntry;

  assign rawLow     = temperature_i < LOW_TH_C;
  assign rawHigh    = temperature_i > HIGH_TH_C;
  assign persistInc = persistCnt_q + PCNT_ONE;

  // Next FSM state and persistence count; only valid samples move the FSM.
  always_comb begin
    state_d      = state_q;
    persistCnt_d = persistCnt_q;
    if (sampleValid_i) begin
      case (state_q)
        ST_NORMAL, ST_PEND_LOW, ST_PEND_HIGH: begin
          if (rawHigh) begin
            if (state_q == ST_PEND_HIGH) begin
              if (persistInc == PERSIST_C) begin
                state_d      = ST_HIGH;
                persistCnt_d = '0;
              end else begin
                persistCnt_d = persistInc;
              end
            end else if (PERSIST == 1) begin
              state_d      = ST_HIGH;
              persistCnt_d = '0;
            end else begin
              state_d      = ST_PEND_HIGH;
              persistCnt_d = PCNT_ONE;
            end
          end else if (rawLow) begin
            if (state_q == ST_PEND_LOW) begin
              if (persistInc == PERSIST_C) begin
                state_d      = ST_LOW;
                persistCnt_d = '0;
              end else begin
                persistCnt_d = persistInc;
              end
            end else if (PERSIST == 1) begin
              state_d      = ST_LOW;
              persistCnt_d = '0;
            end else begin
              state_d      = ST_PEND_LOW;
              persistCnt_d = PCNT_ONE;
            end
          end else begin
            state_d      = ST_NORMAL;
            persistCnt_d = '0;
          end
        end
        ST_HIGH: begin
          if (temperature_i <= HIGH_CLR_C) begin
            if (rawLow) begin
              if (PERSIST == 1) begin
                state_d      = ST_LOW;
                persistCnt_d = '0;
              end else begin
                state_d      = ST_PEND_LOW;
                persistCnt_d = PCNT_ONE;
              end
            end else begin
              state_d      = ST_NORMAL;
              persistCnt_d = '0;
            end
          end
        end
        ST_LOW: begin
          if (temperature_i >= LOW_CLR_C) begin
            if (rawHigh) begin
              if (PERSIST == 1) begin
                state_d      = ST_HIGH;
                persistCnt_d = '0;
              end else begin
                state_d      = ST_PEND_HIGH;
                persistCnt_d = PCNT_ONE;
              end
            end else begin
              state_d      = ST_NORMAL;
              persistCnt_d = '0;
            end
          end
        end
        default: begin
          state_d      = ST_NORMAL;
          persistCnt_d = '0;
        end
      endcase
    end
  end

  // An entry is any move into LOW or HIGH from a different state.
  assign alarmEntry = ((state_d == ST_LOW) || (state_d == ST_HIGH)) && (state_d != state_q);

  // Next event count: clear wins over history but still counts a coincident entry.
  always_comb begin
    eventCount_d = eventCount_q;
    if (clearStats_i) begin
      eventCount_d = alarmEntry ? CNT_W'(1) : '0;
    end else if (alarmEntry && (eventCount_q != {CNT_W{1'b1}})) begin
      eventCount_d = eventCount_q + CNT_W'(1);
    end
  end

  // FSM, persistence, alarm flags and event counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      persistCnt_q <= '0;
      lowAlarm_q   <= 1'b0;
      highAlarm_q  <= 1'b0;
      eventCount_q <= '0;
    end else begin
      state_q      <= state_d;
      persistCnt_q <= persistCnt_d;
      lowAlarm_q   <= (state_d == ST_LOW);
      highAlarm_q  <= (state_d == ST_HIGH);
      eventCount_q <= eventCount_d;
    end
  end

  temp_stats_tracker #(
    .WIDTH(WIDTH)
  ) uStats (
    .clk          (clk),
    .rst          (rst),
    .sampleValid_i(sampleValid_i),
    .sample_i     (temperature_i),
    .clearStats_i (clearStats_i),
    .minTemp_o    (minTemp_o),
    .maxTemp_o    (maxTemp_o),
    .statsValid_o (statsValid_o)
  );

  assign lowTempAbnormality_o  = lowAlarm_q;
  assign highTempAbnormality_o = highAlarm_q;
  assign eventCount_o          = eventCount_q;

endmodule

// File: tb/tb_temp_alarm_monitor.sv
// Bench for temp_alarm_monitor: a default-parameter instance (PERSIST=3) and a
// PERSIST=1 instance share the same directed stimulus. A run-length model
// predicts every output each cycle; directed literals pin the model.
module tb_temp_alarm_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sampleValid = 1'b0;
  logic [7:0] temperature = 8'd0;
  logic       clearStats = 1'b0;
  logic       compareEn = 1'b0;

  logic       lowA, highA, svA;
  logic [7:0] minA, maxA, evA;
  logic       lowB, highB, svB;
  logic [7:0] minB, maxB, evB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  temp_alarm_monitor dut (
    .clk(clk), .rst(rst), .sampleValid_i(sampleValid), .temperature_i(temperature),
    .clearStats_i(clearStats), .lowTempAbnormality_o(lowA), .highTempAbnormality_o(highA),
    .minTemp_o(minA), .maxTemp_o(maxA), .statsValid_o(svA), .eventCount_o(evA)
  );

  temp_alarm_monitor #(.PERSIST(1)) dutP1 (
    .clk(clk), .rst(rst), .sampleValid_i(sampleValid), .temperature_i(temperature),
    .clearStats_i(clearStats), .lowTempAbnormality_o(lowB), .highTempAbnormality_o(highB),
    .minTemp_o(minB), .maxTemp_o(maxB), .statsValid_o(svB), .eventCount_o(evB)
  );

  // alarm: 0 none, 1 low, 2 high; runLow/runHigh: consecutive raw samples seen.
  typedef struct {
    int alarm;
    int runLow;
    int runHigh;
    int events;
    int minT;
    int maxT;
    bit statsV;
  } model_t;

  model_t mA, mB;

  function automatic model_t modelReset();
    model_t r;
    r.alarm = 0; r.runLow = 0; r.runHigh = 0; r.events = 0;
    r.minT = 255; r.maxT = 0; r.statsV = 1'b0;
    return r;
  endfunction

  function automatic model_t modelStep(input model_t m, input bit valid, input int t,
                                       input bit clr, input int persist);
    model_t n = m;
    bit entered = 1'b0;
    if (clr) begin
      n.minT = 255; n.maxT = 0; n.statsV = 1'b0; n.events = 0;
    end
    if (valid) begin
      if (t < n.minT) n.minT = t;
      if (t > n.maxT) n.maxT = t;
      n.statsV = 1'b1;
      if (n.alarm == 2 && t <= 38) begin
        n.alarm = 0; n.runLow = 0; n.runHigh = 0;
      end else if (n.alarm == 1 && t >= 36) begin
        n.alarm = 0; n.runLow = 0; n.runHigh = 0;
      end
      if (n.alarm == 0) begin
        if (t > 39) begin
          n.runHigh = n.runHigh + 1; n.runLow = 0;
        end else if (t < 35) begin
          n.runLow = n.runLow + 1; n.runHigh = 0;
        end else begin
          n.runLow = 0; n.runHigh = 0;
        end
        if (n.runHigh >= persist) begin
          n.alarm = 2; n.runHigh = 0; entered = 1'b1;
        end else if (n.runLow >= persist) begin
          n.alarm = 1; n.runLow = 0; entered = 1'b1;
        end
      end
    end
    if (entered) n.events = (n.events >= 255) ? 255 : n.events + 1;
    return n;
  endfunction

  // Model state advances on the same edges as the DUT registers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mA <= modelReset();
      mB <= modelReset();
    end else begin
      mA <= modelStep(mA, sampleValid, int'(temperature), clearStats, 3);
      mB <= modelStep(mB, sampleValid, int'(temperature), clearStats, 1);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic compareAll(input string tag, input logic low, input logic high,
                            input logic [7:0] minT, input logic [7:0] maxT,
                            input logic sv, input logic [7:0] ev, input model_t m);
    checkOutput({tag, ".low"}, int'(low), (m.alarm == 1) ? 1 : 0);
    checkOutput({tag, ".high"}, int'(high), (m.alarm == 2) ? 1 : 0);
    checkOutput({tag, ".minTemp"}, int'(minT), m.minT);
    checkOutput({tag, ".maxTemp"}, int'(maxT), m.maxT);
    checkOutput({tag, ".statsValid"}, int'(sv), int'(m.statsV));
    checkOutput({tag, ".eventCount"}, int'(ev), m.events);
  endtask

  // Every cycle, away from the active edge, both instances are held to the model.
  always @(negedge clk) begin
    if (compareEn && !rst) begin
      compareAll("model.dut", lowA, highA, minA, maxA, svA, evA, mA);
      compareAll("model.dutP1", lowB, highB, minB, maxB, svB, evB, mB);
    end
  end

  task automatic applyStimulus(input bit valid, input int t, input bit clr);
    @(negedge clk);
    sampleValid = valid;
    temperature = 8'(t);
    clearStats  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #12;
    checkOutput("reset.low", int'(lowA), 0);
    checkOutput("reset.high", int'(highA), 0);
    checkOutput("reset.minTemp", int'(minA), 255);
    checkOutput("reset.maxTemp", int'(maxA), 0);
    checkOutput("reset.statsValid", int'(svA), 0);
    checkOutput("reset.eventCount", int'(evA), 0);
    @(negedge clk);
    rst = 1'b0;
    compareEn = 1'b1;

    // Normal samples only.
    for (int i = 0; i < 4; i++) applyStimulus(1, 37, 0);
    checkOutput("t1.low", int'(lowA), 0);
    checkOutput("t1.high", int'(highA), 0);
    checkOutput("t1.minTemp", int'(minA), 37);
    checkOutput("t1.maxTemp", int'(maxA), 37);
    checkOutput("t1.statsValid", int'(svA), 1);
    checkOutput("t1.eventCount", int'(evA), 0);

    // Three high samples raise the high alarm after the third only.
    applyStimulus(1, 40, 0);
    checkOutput("t2.p1High", int'(highB), 1);
    checkOutput("t2.high1", int'(highA), 0);
    applyStimulus(1, 40, 0);
    checkOutput("t2.high2", int'(highA), 0);
    applyStimulus(1, 40, 0);
    checkOutput("t2.high3", int'(highA), 1);
    checkOutput("t2.eventCount", int'(evA), 1);
    checkOutput("t2.maxTemp", int'(maxA), 40);

    // Hysteresis on the high side, then an interrupted high run.
    applyStimulus(1, 39, 0);
    checkOutput("t3.holdAt39", int'(highA), 1);
    applyStimulus(1, 38, 0);
    checkOutput("t3.clearAt38", int'(highA), 0);
    applyStimulus(1, 40, 0);
    checkOutput("t3.run40a", int'(highA), 0);
    applyStimulus(1, 37, 0);
    checkOutput("t3.run37", int'(highA), 0);
    applyStimulus(1, 40, 0);
    checkOutput("t3.run40b", int'(highA), 0);
    applyStimulus(1, 40, 0);
    checkOutput("t3.run40c", int'(highA), 0);

    // Low run with invalid gaps, then low-side hysteresis.
    applyStimulus(1, 32, 0);
    applyStimulus(0, 99, 0);
    applyStimulus(0, 99, 0);
    applyStimulus(1, 32, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t4.lowBeforeThird", int'(lowA), 0);
    applyStimulus(1, 32, 0);
    checkOutput("t4.lowAfterThird", int'(lowA), 1);
    checkOutput("t4.eventCount", int'(evA), 2);
    applyStimulus(1, 35, 0);
    checkOutput("t4.holdAt35", int'(lowA), 1);
    applyStimulus(1, 36, 0);
    checkOutput("t4.clearAt36", int'(lowA), 0);
    checkOutput("t4.minTemp", int'(minA), 32);

    // From HIGH straight to a raw-low sample.
    for (int i = 0; i < 3; i++) applyStimulus(1, 40, 0);
    checkOutput("t5.high", int'(highA), 1);
    checkOutput("t5.eventCountHigh", int'(evA), 3);
    checkOutput("t5.p1EventsBefore", int'(evB), 5);
    applyStimulus(1, 0, 0);
    checkOutput("t5.highCleared", int'(highA), 0);
    checkOutput("t5.lowPending", int'(lowA), 0);
    checkOutput("t5.p1Low", int'(lowB), 1);
    checkOutput("t5.p1High", int'(highB), 0);
    checkOutput("t5.p1EventCount", int'(evB), 6);
    applyStimulus(1, 0, 0);
    checkOutput("t5.lowSecond", int'(lowA), 0);
    applyStimulus(1, 0, 0);
    checkOutput("t5.lowThird", int'(lowA), 1);
    checkOutput("t5.eventCountLow", int'(evA), 4);

    // Back to HIGH, then asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) applyStimulus(1, 40, 0);
    checkOutput("t6.high", int'(highA), 1);
    checkOutput("t6.eventCount", int'(evA), 5);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6.asyncHigh", int'(highA), 0);
    checkOutput("t6.asyncLow", int'(lowA), 0);
    checkOutput("t6.asyncP1High", int'(highB), 0);
    checkOutput("t6.asyncEventCount", int'(evA), 0);
    checkOutput("t6.asyncStatsValid", int'(svA), 0);
    @(negedge clk);
    sampleValid = 1'b0;
    rst = 1'b0;

    // Clear coincident with a sample.
    applyStimulus(1, 50, 1);
    checkOutput("t6.clrMin", int'(minA), 50);
    checkOutput("t6.clrMax", int'(maxA), 50);
    checkOutput("t6.clrStatsValid", int'(svA), 1);
    checkOutput("t6.clrEventCount", int'(evA), 0);
    checkOutput("t6.clrP1EventCount", int'(evB), 1);
    checkOutput("t6.clrP1High", int'(highB), 1);
    applyStimulus(1, 37, 0);

    // 256 alarm entries saturate the 8-bit counter.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 40, 0);
      applyStimulus(1, 40, 0);
      applyStimulus(1, 40, 0);
      applyStimulus(1, 37, 0);
      if (i == 253) checkOutput("t6.eventCount254", int'(evA), 254);
    end
    checkOutput("t6.saturated", int'(evA), 255);
    checkOutput("t6.p1Saturated", int'(evB), 255);
    checkOutput("t6.satMin", int'(minA), 37);
    checkOutput("t6.satMax", int'(maxA), 50);

    // Clear without a sample leaves alarms untouched.
    for (int i = 0; i < 3; i++) applyStimulus(1, 40, 0);
    checkOutput("t7.highBeforeClear", int'(highA), 1);
    checkOutput("t7.stillSaturated", int'(evA), 255);
    applyStimulus(0, 0, 1);
    checkOutput("t7.highKept", int'(highA), 1);
    checkOutput("t7.p1HighKept", int'(highB), 1);
    checkOutput("t7.eventCount", int'(evA), 0);
    checkOutput("t7.statsValid", int'(svA), 0);
    checkOutput("t7.minTemp", int'(minA), 255);
    checkOutput("t7.maxTemp", int'(maxA), 0);
    applyStimulus(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
